jk_reg_bank: RTL
================

# jk_reg_bank

Parametrised bank of WIDTH JK flip-flop cells sharing one clock and reset, with a runtime mode select that makes the bank act as a JK register, D register, T register, or synchronous binary up-counter built from the same cells. It is the multi-bit, multi-mode successor to the single-bit JK flip-flop. It is used wherever the design needs a small status or control register with per-bit set/reset/toggle semantics or a compact counter. All modes are expressed as per-cell J/K drive, so the storage is always JK cells.

## Interface
- WIDTH, 4: number of JK cells; legal range 1..32.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on async reset and on sync clear.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset; forces q = RESET_VAL, changed = 0.
- mode  in  2  00 JK, 01 D, 10 T, 11 COUNT.
- en  in  1  update enable for the mode operation; when 0, q holds (clr/load still act).
- clr  in  1  synchronous clear to RESET_VAL.
- load  in  1  synchronous parallel load of d.
- d  in  WIDTH  load data; also the data input in D mode.
- j  in  WIDTH  per-cell J in JK mode; per-cell T in T mode.
- k  in  WIDTH  per-cell K in JK mode; ignored in other modes.
- q  out  WIDTH  cell state.
- q_bar  out  WIDTH  ~q, always exact complement, including during reset.
- tc  out  1  combinational terminal count: mode==COUNT & en & q=={WIDTH{1}} & ~clr & ~load.
- changed  out  1  registered; 1 for one cycle after any edge where q changed value.

## Operation
- Priority per rising edge: rst (async) > clr > load > (en & mode op) > hold.
- clr: every cell driven J=RESET_VAL[i], K=~RESET_VAL[i].
- load: J=d[i], K=~d[i].
- JK mode: J=j[i], K=k[i]. 00 hold, 10 set, 01 reset, 11 toggle.
- D mode: J=d[i], K=~d[i]; q <= d.
- T mode: J=K=j[i]; bit toggles where j[i]=1.
- COUNT mode: J=K=carry[i], with carry[0]=1 and carry[i]=&q[i-1:0]. q <= q+1 mod 2^WIDTH. All-ones wraps to 0 with tc=1 during the wrap cycle.
- en=0 with no clr/load: all cells get J=K=0 and hold. tc=0.
- Mode change takes effect on the next edge. No state is carried between modes except q.
- changed <= (q_next != q) on every edge. A clr/load that writes the same value gives changed=0.

## Timing
- q is registered: inputs sampled at rising edge N, q valid after edge N. Zero-cycle combinational path only to q_bar and tc.
- changed lags q by one edge: it is high in the cycle after the edge on which q changed.
- Reset: asserting rst sets q=RESET_VAL, q_bar=~RESET_VAL, changed=0 immediately, without waiting for clk. On deassertion, the first update happens at the first rising edge with rst low.
- Reset mid-count aborts the count. The count restarts from RESET_VAL and does not resume.
- Simultaneous clr and load: clr wins. Simultaneous load and en: load wins, and the mode op is ignored.

## Structure
- Package jk_reg_bank_pkg holds the mode localparams: MODE_JK=2'b00, MODE_D=2'b01, MODE_T=2'b10, MODE_COUNT=2'b11.
- Sub-module jk_cell: one JK flip-flop with async active-high reset.
  - Ports: clk, rst, j, k, q, q_bar.
  - Parameter: RST_VAL.
  - Instantiated WIDTH times in a generate loop.
- Top level contains only the J/K drive mux, the carry chain, tc, and the changed register.

## Test plan
All scenarios use WIDTH=4, RESET_VAL=4'b0000.
1. Reset and hold:
   - Assert rst mid-cycle -> q=0000, q_bar=1111, changed=0 before the next edge.
   - Release rst, en=0 for 3 edges -> q stays 0000.
2. JK mode, en=1:
   - j=1010, k=0000 -> q=1010.
   - Then j=0000, k=0010 -> q=1000.
   - Then j=k=1111 -> q=0111.
   - Then j=k=0000 -> q=0111 and changed=0 one edge later.
3. D and T modes:
   - D mode, d=0110 -> q=0110.
   - Switch to T mode, j=0011 -> q=0101, then 0110.
4. COUNT mode, en=1, from 0000:
   - 15 edges -> q=1111 and tc=1.
   - 16th edge -> q=0000 and tc=0.
   - en=0 for 2 edges -> q holds 0000.
5. Priority:
   - COUNT mode with clr=1 and load=1, d=1001 -> q=0000.
   - Then load=1 only -> q=1001.
   - Then load=0 -> q=1010.
6. Async reset during count:
   - rst pulse at q=0101 -> q=0000 immediately.
   - Count resumes 0001 at the first edge after release.

Source files
------------

// File: rtl/jk_reg_bank_pkg.sv
// rtl/jk_reg_bank_pkg.sv - mode encodings shared by the JK register bank and its users
package jk_reg_bank_pkg;

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_D     = 2'b01;
    localparam logic [1:0] MODE_T     = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

endpackage

// File: rtl/jk_reg_bank_cell.sv
// rtl/jk_reg_bank_cell.sv - single JK flip-flop cell with async active-high reset
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, loads RST_VAL
//   j, k  JK drive: 00 hold, 10 set, 01 reset, 11 toggle
//   q     cell state
//   q_bar complement of q
module jk_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - multi-mode register bank (JK / D / T / counter) built from JK cells
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset: q = RESET_VAL, changed = 0
//   mode     00 JK, 01 D, 10 T, 11 COUNT
//   en       enables the mode operation; clr/load act regardless
//   clr      synchronous clear to RESET_VAL (highest synchronous priority)
//   load     synchronous parallel load of d
//   d        load data, and data input in D mode
//   j        per-cell J in JK mode, per-cell T in T mode
//   k        per-cell K in JK mode
//   q        cell state
//   q_bar    complement of q
//   tc       combinational terminal count in COUNT mode
//   changed  high for one cycle after an edge on which q changed
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             changed
);

    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] q_next;

    // Ripple carry for the counter: a cell toggles when every lower cell is 1.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & q[i-1];
        end
    end

    // Every operation is expressed as J/K drive so storage stays pure JK cells.
    always_comb begin
        j_drv = '0;
        k_drv = '0;
        if (clr) begin
            j_drv = RESET_VAL;
            k_drv = ~RESET_VAL;
        end else if (load) begin
            j_drv = d;
            k_drv = ~d;
        end else if (en) begin
            case (mode)
                MODE_JK: begin
                    j_drv = j;
                    k_drv = k;
                end
                MODE_D: begin
                    j_drv = d;
                    k_drv = ~d;
                end
                MODE_T: begin
                    j_drv = j;
                    k_drv = j;
                end
                default: begin
                    j_drv = carry;
                    k_drv = carry;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell #(
                .RST_VAL (RESET_VAL[gi])
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .j     (j_drv[gi]),
                .k     (k_drv[gi]),
                .q     (q[gi]),
                .q_bar (q_bar[gi])
            );
        end
    endgenerate

    // Characteristic equation of a JK cell, used only to detect a change ahead of the edge.
    assign q_next = (j_drv & ~q) | (~k_drv & q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= (q_next != q);
        end
    end

    assign tc = (mode == MODE_COUNT) & en & (&q) & ~clr & ~load;

endmodule
